// File: rtl/lock_ctrl_if.sv
// Panel-side signal bundle for the combination lock controller.
//
// Signals:
//   btn        keypad level inputs, one bit per key 0..3 (debounced, asynchronous to clk)
//   set_mode   level request to reprogram the code while the lock is open
//   unlocked   lock open (OPEN or PROGRAM)
//   err_light  error indicator (ERROR or LOCKOUT)
//   lockout    too many consecutive wrong codes
//   prog_mode  code reprogramming in progress
//   digit_cnt  digits collected so far in the current entry
//
// Modports:
//   slave      the controller (takes buttons, drives lights)
//   master     the panel / stimulus side
interface lock_ctrl_if;
    logic [3:0] btn;
    logic       set_mode;
    logic       unlocked;
    logic       err_light;
    logic       lockout;
    logic       prog_mode;
    logic [2:0] digit_cnt;

    modport slave (
        input  btn,
        input  set_mode,
        output unlocked,
        output err_light,
        output lockout,
        output prog_mode,
        output digit_cnt
    );

    modport master (
        output btn,
        output set_mode,
        input  unlocked,
        input  err_light,
        input  lockout,
        input  prog_mode,
        input  digit_cnt
    );
endinterface

// File: rtl/lock_ctrl.sv
// Combination lock sequencing controller.
//
// Samples the keypad, turns each release-to-press transition into one digit event, checks
// entered sequences against the stored code and drives the panel lights. While open, the
// code can be reprogrammed by holding set_mode and keying in a new sequence.
//
// Ports:
//   clk_i    single clock, rising edge
//   rst_ni   asynchronous active-low reset
//   bus_io   lock_ctrl_if.slave: btn/set_mode in; unlocked, err_light, lockout,
//            prog_mode, digit_cnt out (all outputs registered, decoded from next state)
module lock_ctrl #(
    parameter int unsigned            CODE_LEN     = 4,
    parameter logic [2*CODE_LEN-1:0]  DEFAULT_CODE = 8'hE4,
    parameter int unsigned            MAX_FAIL     = 3,
    parameter int unsigned            ERR_CYC      = 200,
    parameter int unsigned            LOCKOUT_CYC  = 2000,
    parameter int unsigned            UNLOCK_CYC   = 1000
) (
    input logic        clk_i,
    input logic        rst_ni,
    lock_ctrl_if.slave bus_io
);

    localparam int unsigned CW      = 2 * CODE_LEN;
    localparam int unsigned DIG_W   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int unsigned FAIL_W  = $clog2(MAX_FAIL + 1);
    localparam int unsigned MAX_CYC =
        (ERR_CYC > LOCKOUT_CYC) ? ((ERR_CYC > UNLOCK_CYC) ? ERR_CYC : UNLOCK_CYC)
                                : ((LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC);
    localparam int unsigned TMR_W   = ($clog2(MAX_CYC) > 0) ? $clog2(MAX_CYC) : 1;

    // The timer is loaded with N-1 and the state leaves on the cycle after it reads 0,
    // giving exactly N cycles in each timed state.
    localparam logic [TMR_W-1:0] ERR_LOAD     = TMR_W'(ERR_CYC - 1);
    localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYC - 1);
    localparam logic [TMR_W-1:0] UNLOCK_LOAD  = TMR_W'(UNLOCK_CYC - 1);
    localparam logic [DIG_W-1:0] LAST_DIGIT   = DIG_W'(CODE_LEN - 1);
    localparam logic [FAIL_W-1:0] FAIL_LIMIT  = FAIL_W'(MAX_FAIL);

    typedef enum logic [2:0] {
        StLocked,
        StError,
        StLockout,
        StOpen,
        StProgram
    } state_e;

    // Input sampling: btn_q is the first sample, btn_prev_q the one before it.
    logic [3:0]        btn_q, btn_prev_q;

    state_e            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [FAIL_W-1:0] fail_q, fail_d;
    logic [DIG_W-1:0]  dcnt_q, dcnt_d;
    logic              mism_q, mism_d;
    logic [CW-1:0]     code_q, code_d;
    logic [CW-1:0]     stage_q, stage_d;
    logic [DIG_W-1:0]  pcnt_q, pcnt_d;

    logic              unlocked_q, err_q, lockout_q, prog_q;
    logic [2:0]        dcnt_out_q;

    logic              press_ev;
    logic              good_digit;
    logic [1:0]        digit_val;
    logic [1:0]        code_dig;
    logic              mism_new;
    logic [FAIL_W-1:0] fail_inc;
    logic [CW-1:0]     stage_new;

    // One event per release-to-press; extra keys added while one is held are ignored.
    assign press_ev   = (btn_prev_q == 4'b0000) && (btn_q != 4'b0000);
    assign good_digit = (btn_q != 4'b0000) && ((btn_q & (btn_q - 4'd1)) == 4'b0000);
    assign code_dig   = code_q[{dcnt_q, 1'b0} +: 2];

    always_comb begin
        digit_val = 2'd0;
        unique case (btn_q)
            4'b0001: digit_val = 2'd0;
            4'b0010: digit_val = 2'd1;
            4'b0100: digit_val = 2'd2;
            4'b1000: digit_val = 2'd3;
            default: digit_val = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        fail_d  = fail_q;
        dcnt_d  = dcnt_q;
        mism_d  = mism_q;
        code_d  = code_q;
        stage_d = stage_q;
        pcnt_d  = pcnt_q;

        mism_new  = mism_q | ~good_digit | (digit_val != code_dig);
        fail_inc  = (fail_q >= FAIL_LIMIT) ? fail_q : fail_q + FAIL_W'(1);
        // Digit 0 is entered first and must end up in the low bits, so shift in from the top.
        stage_new = {digit_val, stage_q[CW-1:2]};

        unique case (state_q)
            StLocked: begin
                if (press_ev) begin
                    if (dcnt_q == LAST_DIGIT) begin
                        dcnt_d = '0;
                        mism_d = 1'b0;
                        if (!mism_new) begin
                            state_d = StOpen;
                            tmr_d   = UNLOCK_LOAD;
                            fail_d  = '0;
                        end else begin
                            fail_d = fail_inc;
                            if (fail_inc >= FAIL_LIMIT) begin
                                state_d = StLockout;
                                tmr_d   = LOCKOUT_LOAD;
                            end else begin
                                state_d = StError;
                                tmr_d   = ERR_LOAD;
                            end
                        end
                    end else begin
                        dcnt_d = dcnt_q + DIG_W'(1);
                        mism_d = mism_new;
                    end
                end
            end
            StError: begin
                if (tmr_q == '0) begin
                    state_d = StLocked;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            StLockout: begin
                if (tmr_q == '0) begin
                    state_d = StLocked;
                    fail_d  = '0;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            StOpen: begin
                // set_mode takes priority even on the cycle the open window expires.
                if (bus_io.set_mode) begin
                    state_d = StProgram;
                    pcnt_d  = '0;
                end else if (tmr_q == '0) begin
                    state_d = StLocked;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            StProgram: begin
                // Dropping set_mode aborts, and wins over a same-cycle digit.
                if (!bus_io.set_mode) begin
                    state_d = StLocked;
                    pcnt_d  = '0;
                end else if (press_ev) begin
                    if (!good_digit) begin
                        state_d = StLocked;
                        pcnt_d  = '0;
                    end else if (pcnt_q == LAST_DIGIT) begin
                        code_d  = stage_new;
                        state_d = StLocked;
                        pcnt_d  = '0;
                    end else begin
                        stage_d = stage_new;
                        pcnt_d  = pcnt_q + DIG_W'(1);
                    end
                end
            end
            default: begin
                state_d = StLocked;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            btn_q      <= 4'b0000;
            btn_prev_q <= 4'b0000;
            state_q    <= StLocked;
            tmr_q      <= '0;
            fail_q     <= '0;
            dcnt_q     <= '0;
            mism_q     <= 1'b0;
            code_q     <= DEFAULT_CODE;
            stage_q    <= '0;
            pcnt_q     <= '0;
            unlocked_q <= 1'b0;
            err_q      <= 1'b0;
            lockout_q  <= 1'b0;
            prog_q     <= 1'b0;
            dcnt_out_q <= 3'd0;
        end else begin
            btn_q      <= bus_io.btn;
            btn_prev_q <= btn_q;
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            fail_q     <= fail_d;
            dcnt_q     <= dcnt_d;
            mism_q     <= mism_d;
            code_q     <= code_d;
            stage_q    <= stage_d;
            pcnt_q     <= pcnt_d;
            // Outputs come from the next state so they line up with the state register.
            unlocked_q <= (state_d == StOpen) || (state_d == StProgram);
            err_q      <= (state_d == StError) || (state_d == StLockout);
            lockout_q  <= (state_d == StLockout);
            prog_q     <= (state_d == StProgram);
            dcnt_out_q <= 3'(dcnt_d);
        end
    end

    assign bus_io.unlocked  = unlocked_q;
    assign bus_io.err_light = err_q;
    assign bus_io.lockout   = lockout_q;
    assign bus_io.prog_mode = prog_q;
    assign bus_io.digit_cnt = dcnt_out_q;

endmodule

// File: doc/lock_ctrl.md
# lock_ctrl

Sequencing controller for the combination lock. It samples the keypad buttons, turns each clean press into a digit, and compares the entered sequence against a stored code. It drives the unlock, error and lockout lights, and handles code reprogramming while the lock is open. It sits between the raw button inputs and the panel lights; all press detection is internal, so no external level-to-pulse stage is needed.

## Interface
- `CODE_LEN`, 4: digits per code.
- `DEFAULT_CODE`, 8'hE4: reset code. Digit i is bits [2i+1:2i]; digit 0 is entered first. 8'hE4 is the sequence 0,1,2,3. Width is 2*CODE_LEN.
- `MAX_FAIL`, 3: consecutive wrong codes that trigger lockout.
- `ERR_CYC`, 200: cycles the error state lasts.
- `LOCKOUT_CYC`, 2000: cycles the lockout state lasts.
- `UNLOCK_CYC`, 1000: cycles the lock stays open with no programming.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `btn` in 4: keypad level inputs, one bit per key 0..3. Already debounced and asynchronous to `clk`.
- `set_mode` in 1: level input; requests programming while open.
- `unlocked` out 1: high in OPEN and PROGRAM.
- `err_light` out 1: high in ERROR and LOCKOUT.
- `lockout` out 1: high in LOCKOUT.
- `prog_mode` out 1: high in PROGRAM.
- `digit_cnt` out 3: digits collected so far in the current entry, 0..CODE_LEN-1.

## Operation
- **Input sampling:** `btn` is registered into `btn_q`, then into `btn_d`.
- **Press event:** occurs when `btn_d` == 0 and `btn_q` != 0. A press is therefore counted once, on release-to-press; further keys pressed while any key is held are ignored.
- **Event classification:**
  - `btn_q` one-hot: good digit, value = index of the set bit.
  - Otherwise: bad digit.
- **States:**
  - LOCKED (reset state):
    - Each event stores its digit index `digit_cnt` and sets a sticky mismatch flag if the digit is bad or differs from code digit `digit_cnt`.
    - On the CODE_LEN-th event, with no mismatch → OPEN and `fail_cnt` ← 0.
    - On the CODE_LEN-th event, with a mismatch → `fail_cnt`+1. If that reaches MAX_FAIL → LOCKOUT; else → ERROR.
    - `digit_cnt` and the mismatch flag clear on every exit from LOCKED.
  - ERROR: events ignored; after ERR_CYC cycles → LOCKED.
  - LOCKOUT: events ignored; after LOCKOUT_CYC cycles → LOCKED, `fail_cnt` ← 0.
  - OPEN:
    - If `set_mode` is high on any cycle → PROGRAM.
    - Otherwise → LOCKED after UNLOCK_CYC cycles.
    - Events in OPEN are ignored.
  - PROGRAM:
    - Good digits shift into a staging register.
    - After CODE_LEN good digits: code ← staged value, then → LOCKED.
    - A bad digit, or `set_mode` low on any cycle, aborts → LOCKED with the code unchanged.
- **Timer:** one shared down-counter, loaded with N-1 on state entry. The state exits on the cycle after the counter reads 0, so each timed state lasts exactly N cycles.
- **Failure counter:** `fail_cnt` saturates at MAX_FAIL and is never decremented except by the clears above.

## Timing
- **Reset values:**
  - All outputs 0.
  - State LOCKED; `fail_cnt` 0; `digit_cnt` 0.
  - Code = DEFAULT_CODE; `btn_q` and `btn_d` = 0.
- **Reset mid-operation:** any state returns to LOCKED immediately, and a programmed code reverts to DEFAULT_CODE.
- **Registered outputs:** all outputs are registered and decoded from the next state.
- **Latency:** if `btn` is first sampled high at edge N, the event is acted on at edge N+1, and outputs reflect the new state after edge N+1.
- **Final digit:** a code completed by an event at edge N+1 shows `unlocked`/`err_light` from edge N+1.
- **Simultaneous press:** two keys rising on the same edge count as one bad digit.
- **`set_mode` with an event:** in PROGRAM, the `set_mode` abort wins over a same-cycle event.
- **`set_mode` and timer expiry:** in OPEN, `set_mode` high on the cycle the timer expires still takes PROGRAM.

## Test plan
- **Correct default code:** reset, then presses 0,1,2,3 each held 5 cycles with 5-cycle gaps.
  - `unlocked`=1 for exactly 1000 cycles, then 0.
  - `digit_cnt` steps 1,2,3 during entry, then 0.
- **Wrong code:** presses 0,1,2,2.
  - `err_light`=1 for 200 cycles.
  - Then entering 0,1,2,3 unlocks.
- **Lockout:** three wrong codes.
  - After the third, `lockout`=`err_light`=1 for 2000 cycles.
  - Presses of 0,1,2,3 during lockout have no effect.
  - Afterwards, a single wrong code gives ERROR, not LOCKOUT.
- **Multi-key press:** `btn`=4'b0011 rising together as the second digit of 0,x,2,3 → ERROR.
  - A key pressed while another is held produces no event.
- **Reprogramming:**
  - Open the lock, raise `set_mode`, enter 3,3,1,0 → `prog_mode`=1, then LOCKED.
  - 3,3,1,0 now unlocks and 0,1,2,3 gives ERROR.
  - Repeat, dropping `set_mode` after 2 digits → code unchanged.
- **Reset during OPEN:** assert `rst` low mid-window after reprogramming.
  - All outputs are 0 immediately.
  - 0,1,2,3 unlocks again.
